// File: rtl/wb_pkg.sv
// Shared writeback types: default widths, request struct, starve limit, onehot decode.
package wb_pkg;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_DATA_W   = 32;
  localparam int STARVE_LIMIT = 15;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [2**DEF_ADDR_W-1:0] onehot(input logic [DEF_ADDR_W-1:0] a);
    logic [2**DEF_ADDR_W-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Parameterised sync FIFO; also exposes every slot plus a per-slot valid mask so
// the owner can build a scoreboard over buffered entries.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic [CNT_W-1:0]             count,
  output logic                         full,
  output logic                         empty,
  output logic [DEPTH-1:0][WIDTH-1:0]  slots,
  output logic [DEPTH-1:0]             slot_vld
);
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            rd_ptr, wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign slots = mem;

  // Slot i is live when its distance from the read pointer is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_vld
    logic [PTR_W-1:0] off;
    assign off         = PTR_W'(i) - rd_ptr;
    assign slot_vld[i] = (CNT_W'(off) < count);
  end
endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: pipeline writes win, multi-cycle results drain
// from a FIFO. Optional starvation guard under WB_ARB_STARVE_GUARD_EN.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int NREG  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_wr,
  input  logic [DATA_W-1:0] pipe_data,
  output logic              pipe_stall,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [ADDR_W-1:0] mc_wr,
  input  logic [DATA_W-1:0] mc_data,
  output logic [ADDR_W-1:0] wr,
  output logic [DATA_W-1:0] data_in,
  output logic              reg_write,
  output logic [NREG-1:0]   pending,
  output logic [CNT_W-1:0]  fifo_count
);
  localparam int REQ_W = $bits(wb_req_t);

  logic                        full, empty, push, pop, pipe_acc;
  wb_req_t                     mc_req, head;
  logic [DEPTH-1:0][REQ_W-1:0] slots;
  logic [DEPTH-1:0]            slot_vld;

  assign mc_req   = '{addr: mc_wr, data: mc_data};
  assign mc_ready = rst_n && !full;
  assign push     = mc_valid && mc_ready;

  wb_fifo #(.WIDTH(REQ_W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .din      (mc_req),
    .pop      (pop),
    .dout     (head),
    .count    (fifo_count),
    .full     (full),
    .empty    (empty),
    .slots    (slots),
    .slot_vld (slot_vld)
  );

`ifdef WB_ARB_STARVE_GUARD_EN
  logic [3:0] age;
  logic       force_pop;

  assign force_pop  = !empty && (age == 4'(STARVE_LIMIT));
  assign pipe_stall = force_pop;
  assign pipe_acc   = pipe_we && !force_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              age <= '0;
    else if (empty || pop)   age <= '0;
    else                     age <= age + 1'b1;
  end
`else
  assign pipe_stall = 1'b0;
  assign pipe_acc   = pipe_we;
`endif

  assign pop = !empty && !pipe_acc;

  // Register 0 writes still occupy the output stage but never assert the enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write <= 1'b0;
      wr        <= '0;
      data_in   <= '0;
    end else if (pipe_acc) begin
      reg_write <= (pipe_wr != '0);
      wr        <= pipe_wr;
      data_in   <= pipe_data;
    end else if (pop) begin
      reg_write <= (head.addr != '0);
      wr        <= head.addr;
      data_in   <= head.data;
    end else begin
      reg_write <= 1'b0;
    end
  end

  always_comb begin
    wb_req_t s;
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      s = wb_req_t'(slots[i]);
      if (slot_vld[i]) pending |= onehot(s.addr);
    end
    if (reg_write) pending |= onehot(wr);
    pending[0] = 1'b0;
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter; starvation-guard scenario runs when the macro is set.
module tb_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_we;
  logic [4:0]  pipe_wr;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_wr;
  logic [31:0] mc_data;
  logic [4:0]  wr;
  logic [31:0] data_in;
  logic        reg_write;
  logic [31:0] pending;
  logic [2:0]  fifo_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_we    (pipe_we),
    .pipe_wr    (pipe_wr),
    .pipe_data  (pipe_data),
    .pipe_stall (pipe_stall),
    .mc_valid   (mc_valid),
    .mc_ready   (mc_ready),
    .mc_wr      (mc_wr),
    .mc_data    (mc_data),
    .wr         (wr),
    .data_in    (data_in),
    .reg_write  (reg_write),
    .pending    (pending),
    .fifo_count (fifo_count)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pipe_we = 1'b0; pipe_wr = '0; pipe_data = '0;
    mc_valid = 1'b1; mc_wr = 5'd2; mc_data = 32'h55;
    repeat (3) tick();
    chk("rst_reg_write", reg_write, 0);
    chk("rst_pending",   pending, 0);
    chk("rst_mc_ready",  mc_ready, 0);
    chk("rst_count",     fifo_count, 0);
    chk("rst_wr",        wr, 0);
    mc_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    chk("rel_mc_ready", mc_ready, 1);
    chk("rel_stall",    pipe_stall, 0);

    // pipeline only
    pipe_we = 1'b1; pipe_wr = 5'd5; pipe_data = 32'hDEADBEEF;
    tick();
    pipe_we = 1'b0;
    chk("pipe_we_out", reg_write, 1);
    chk("pipe_wr",     wr, 5);
    chk("pipe_data",   data_in, 32'hDEADBEEF);
    chk("pipe_pend",   pending, 32'h20);
    tick();
    chk("pipe_idle_we",   reg_write, 0);
    chk("pipe_pend_clr",  pending, 0);
    chk("pipe_hold_data", data_in, 32'hDEADBEEF);

    // multi-cycle path
    mc_valid = 1'b1; mc_wr = 5'd7; mc_data = 32'h12;
    tick();
    mc_valid = 1'b0;
    chk("mc_pend_n1", pending, 32'h80);
    chk("mc_cnt_n1",  fifo_count, 1);
    chk("mc_we_n1",   reg_write, 0);
    tick();
    chk("mc_we_n2",   reg_write, 1);
    chk("mc_wr_n2",   wr, 7);
    chk("mc_data_n2", data_in, 32'h12);
    chk("mc_cnt_n2",  fifo_count, 0);
    chk("mc_pend_n2", pending, 32'h80);
    tick();
    chk("mc_pend_n3", pending, 0);

    // priority and fill: pipeline keeps the port while 4 mc entries queue up
    for (int k = 0; k < 4; k++) begin
      pipe_we = 1'b1; pipe_wr = 5'(20 + k); pipe_data = 32'(100 + k);
      mc_valid = 1'b1; mc_wr = 5'(k + 1); mc_data = 32'(256 + k);
      tick();
      chk("fill_we", reg_write, 1);
      chk("fill_wr", wr, 64'(20 + k));
    end
    mc_valid = 1'b0;
    chk("fill_cnt",   fifo_count, 4);
    chk("fill_ready", mc_ready, 0);
    chk("fill_pend",  pending, 32'h0080_001E);
    pipe_wr = 5'd24; pipe_data = 32'd104;
    tick();
    chk("full_pipe_wr", wr, 24);
    chk("full_cnt",     fifo_count, 4);
    pipe_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("drain_we",   reg_write, 1);
      chk("drain_wr",   wr, 64'(k + 1));
      chk("drain_data", data_in, 64'(256 + k));
      chk("drain_cnt",  fifo_count, 64'(3 - k));
    end
    tick();
    chk("drain_idle", reg_write, 0);
    chk("drain_ready", mc_ready, 1);

    // register 0 from the pipeline with reg 3 buffered
    pipe_we = 1'b1; pipe_wr = 5'd12; pipe_data = 32'h1;
    mc_valid = 1'b1; mc_wr = 5'd3; mc_data = 32'h33;
    tick();
    mc_valid = 1'b0;
    pipe_wr = 5'd0; pipe_data = 32'hBAD;
    tick();
    pipe_we = 1'b0;
    chk("r0_we",   reg_write, 0);
    chk("r0_cnt",  fifo_count, 1);
    chk("r0_pend", pending, 32'h8);
    tick();
    chk("r0_next_we", reg_write, 1);
    chk("r0_next_wr", wr, 3);

    // register 0 through the FIFO
    mc_valid = 1'b1; mc_wr = 5'd0; mc_data = 32'hBAD;
    tick();
    mc_valid = 1'b0;
    chk("mc0_cnt",  fifo_count, 1);
    chk("mc0_pend", pending, 0);
    tick();
    chk("mc0_cnt_pop", fifo_count, 0);
    chk("mc0_we",      reg_write, 0);

`ifdef WB_ARB_STARVE_GUARD_EN
    pipe_we = 1'b1; pipe_wr = 5'd11; pipe_data = 32'hB;
    mc_valid = 1'b1; mc_wr = 5'd9; mc_data = 32'h99;
    tick();
    mc_valid = 1'b0;
    for (int k = 1; k < 16; k++) begin
      chk("starve_wait_stall", pipe_stall, 0);
      chk("starve_wait_wr",    wr, 11);
      tick();
    end
    chk("starve_stall", pipe_stall, 1);
    chk("starve_cnt",   fifo_count, 1);
    tick();
    chk("starve_we",   reg_write, 1);
    chk("starve_wr",   wr, 9);
    chk("starve_cnt0", fifo_count, 0);
    chk("starve_stall_off", pipe_stall, 0);
    tick();
    chk("starve_pipe_wr", wr, 11);
    pipe_we = 1'b0;
`else
    pipe_we = 1'b1; pipe_wr = 5'd11; pipe_data = 32'hB;
    mc_valid = 1'b1; mc_wr = 5'd9; mc_data = 32'h99;
    tick();
    mc_valid = 1'b0;
    repeat (20) tick();
    chk("nostarve_stall", pipe_stall, 0);
    chk("nostarve_cnt",   fifo_count, 1);
    chk("nostarve_wr",    wr, 11);
    pipe_we = 1'b0;
    tick();
    chk("nostarve_pop_wr", wr, 9);
`endif

    // reset mid-operation drops buffered entries
    tick();
    pipe_we = 1'b1; pipe_wr = 5'd13; pipe_data = 32'hD;
    mc_valid = 1'b1; mc_wr = 5'd6; mc_data = 32'h66;
    tick();
    mc_valid = 1'b0; pipe_we = 1'b0;
    chk("mid_cnt_pre", fifo_count, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_cnt",  fifo_count, 0);
    chk("mid_pend", pending, 0);
    chk("mid_we",   reg_write, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_after_we", reg_write, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
